// File: rtl/jtkcpu_exgtfr_wb_pkg.sv
// EXG/TFR writeback shared definitions:
// opcodes, fill byte, register codes, FSM states.
package jtkcpu_exgtfr_wb_pkg;
  localparam logic [7:0] EXG_OP = 8'h3E;
  localparam logic [7:0] TFR_OP = 8'h3F;
  localparam logic [7:0] HIFILL = 8'hFF;

  localparam logic [3:0] REG_D  = 4'h0;
  localparam logic [3:0] REG_X  = 4'h1;
  localparam logic [3:0] REG_Y  = 4'h2;
  localparam logic [3:0] REG_U  = 4'h3;
  localparam logic [3:0] REG_S  = 4'h4;
  localparam logic [3:0] REG_PC = 4'h5;
  localparam logic [3:0] REG_A  = 4'h8;
  localparam logic [3:0] REG_B  = 4'h9;
  localparam logic [3:0] REG_CC = 4'hA;
  localparam logic [3:0] REG_DP = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    WR_HI,
    WR_LO
  } state_t;
endpackage

// File: rtl/jtkcpu_exgtfr_wb_if.sv
// Decoder request + register-bank write bus.
// master: start/op/postbyte out; slave: busy/we/wr_id/wr_data/done/illegal out.
interface jtkcpu_exgtfr_wb_if;
  logic        start;
  logic [7:0]  op;
  logic [7:0]  postbyte;
  logic        busy;
  logic        we;
  logic [3:0]  wr_id;
  logic [15:0] wr_data;
  logic        done;
  logic        illegal;

  modport master (
    output start, op, postbyte,
    input  busy, we, wr_id, wr_data,
    input  done, illegal
  );

  modport slave (
    input  start, op, postbyte,
    output busy, we, wr_id, wr_data,
    output done, illegal
  );
endinterface

// File: rtl/jtkcpu_exgtfr_wb_regmux.sv
// Register code -> 16-bit value selector.
// Ports: code_i, register values in; data_o, def_o (code is defined) out.
module jtkcpu_regmux
  import jtkcpu_exgtfr_wb_pkg::*;
(
  input  logic [3:0]  code_i,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  dp,
  input  logic [7:0]  cc,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] u,
  input  logic [15:0] s,
  input  logic [15:0] pc,
  output logic [15:0] data_o,
  output logic        def_o
);
  always_comb begin
    data_o = 16'h0000;
    def_o  = 1'b1;
    case (code_i)
      REG_D:   data_o = {a, b};
      REG_X:   data_o = x;
      REG_Y:   data_o = y;
      REG_U:   data_o = u;
      REG_S:   data_o = s;
      REG_PC:  data_o = pc;
      REG_A:   data_o = {HIFILL, a};
      REG_B:   data_o = {HIFILL, b};
      REG_CC:  data_o = {HIFILL, cc};
      REG_DP:  data_o = {HIFILL, dp};
      default: def_o  = 1'b0;
    endcase
  end
endmodule

// File: rtl/jtkcpu_exgtfr_wb.sv
// EXG/TFR writeback sequencer: snapshot both registers, then 1 or 2 writes.
// Ports: clk, rst_n, cen, register values, bus (slave). Option: JTKCPU_EXGTFR_CHK_EN.
module jtkcpu_exgtfr_wb
  import jtkcpu_exgtfr_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  dp,
  input  logic [7:0]  cc,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] u,
  input  logic [15:0] s,
  input  logic [15:0] pc,
  jtkcpu_exgtfr_wb_if.slave bus
);
  state_t      st_q, st_d;
  logic        exg_q;
  logic [7:0]  pb_q;
  logic [15:0] tmpa_q, tmpb_q;
  logic        done_q, done_d;
  logic [15:0] r1, r2;
  logic        def1, def2;
  logic        we;
  logic [3:0]  wr_id;
  logic [15:0] wr_data;
  logic        op_ok;

  assign op_ok = (bus.op == EXG_OP) |
                 (bus.op == TFR_OP);

  jtkcpu_regmux u_r1 (
    .code_i(pb_q[7:4]), .a(a), .b(b),
    .dp(dp), .cc(cc), .x(x), .y(y),
    .u(u), .s(s), .pc(pc),
    .data_o(r1), .def_o(def1)
  );

  jtkcpu_regmux u_r2 (
    .code_i(pb_q[3:0]), .a(a), .b(b),
    .dp(dp), .cc(cc), .x(x), .y(y),
    .u(u), .s(s), .pc(pc),
    .data_o(r2), .def_o(def2)
  );

`ifdef JTKCPU_EXGTFR_CHK_EN
  logic ill_q, ill_d;
  logic bad;
  // 8-bit codes have bit 3 set among defined codes
  assign bad = ~def1 | ~def2 |
               (pb_q[7] ^ pb_q[3]);
  assign bus.illegal = ill_q;
`else
  assign bus.illegal = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    done_d  = done_q;
`ifdef JTKCPU_EXGTFR_CHK_EN
    ill_d   = ill_q;
`endif
    we      = 1'b0;
    wr_id   = 4'h0;
    wr_data = 16'h0000;
    if (cen) begin
      done_d = 1'b0;
`ifdef JTKCPU_EXGTFR_CHK_EN
      ill_d  = 1'b0;
`endif
      unique case (st_q)
        IDLE: begin
          if (bus.start & op_ok)
            st_d = SNAP;
`ifdef JTKCPU_EXGTFR_CHK_EN
          else if (bus.start) begin
            done_d = 1'b1;
            ill_d  = 1'b1;
          end
`endif
        end
        SNAP:  st_d = exg_q ? WR_HI : WR_LO;
        WR_HI: st_d = WR_LO;
        WR_LO: begin
          st_d   = IDLE;
          done_d = 1'b1;
`ifdef JTKCPU_EXGTFR_CHK_EN
          ill_d  = bad;
`endif
        end
      endcase
    end
    unique case (st_q)
      WR_HI: begin
        wr_id   = pb_q[7:4];
        wr_data = tmpb_q;
        we      = cen & def1;
      end
      WR_LO: begin
        wr_id   = pb_q[3:0];
        wr_data = tmpa_q;
        we      = cen & def2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      exg_q  <= 1'b0;
      pb_q   <= 8'h00;
      tmpa_q <= 16'h0000;
      tmpb_q <= 16'h0000;
      done_q <= 1'b0;
`ifdef JTKCPU_EXGTFR_CHK_EN
      ill_q  <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      done_q <= done_d;
`ifdef JTKCPU_EXGTFR_CHK_EN
      ill_q  <= ill_d;
`endif
      if (cen && st_q == IDLE &&
          bus.start && op_ok) begin
        exg_q <= (bus.op == EXG_OP);
        pb_q  <= bus.postbyte;
      end
      // snapshot so EXG's second write ignores the first
      if (cen && st_q == SNAP) begin
        tmpa_q <= r1;
        tmpb_q <= r2;
      end
    end
  end

  assign bus.busy    = (st_q != IDLE);
  assign bus.we      = we;
  assign bus.wr_id   = wr_id;
  assign bus.wr_data = wr_data;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_jtkcpu_exgtfr_wb.sv
// Bench for jtkcpu_exgtfr_wb: vector table + write scoreboard
// against a small register bank model.
module tb_jtkcpu_exgtfr_wb;
  import jtkcpu_exgtfr_wb_pkg::*;

`ifdef JTKCPU_EXGTFR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b1;
  logic cen_tog = 1'b0;
  int   ld = 0;
  logic [7:0]  ra, rb, rdp, rcc;
  logic [15:0] rx, ry, ru, rs, rpc;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  typedef struct {
    logic [3:0]  id;
    logic [15:0] d;
  } wr_t;
  wr_t q[$];

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  pb;
    int          n;
    logic [3:0]  id0;
    logic [15:0] d0;
    logic [3:0]  id1;
    logic [15:0] d1;
    bit          ill;
  } vec_t;
  vec_t tv[10];

  jtkcpu_exgtfr_wb_if ifc ();

  jtkcpu_exgtfr_wb dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .a(ra), .b(rb), .dp(rdp), .cc(rcc),
    .x(rx), .y(ry), .u(ru), .s(rs),
    .pc(rpc), .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cen_tog) begin
      #2 cen = ~cen;
    end
  end

  // register bank model
  always @(posedge clk) begin
    if (ld == 1) begin
      ra <= 8'h5A; rb <= 8'hC3;
      rdp <= 8'h11; rcc <= 8'h22;
      rx <= 16'h1234; ry <= 16'h5678;
      ru <= 16'h9ABC; rs <= 16'hDEF0;
      rpc <= 16'h8003;
    end else if (ld == 2) begin
      ra <= 8'hBE; rb <= 8'hEF;
      rx <= 16'h0042;
    end else if (ifc.we) begin
      case (ifc.wr_id)
        4'h0: {ra, rb} <= ifc.wr_data;
        4'h1: rx <= ifc.wr_data;
        4'h2: ry <= ifc.wr_data;
        4'h3: ru <= ifc.wr_data;
        4'h4: rs <= ifc.wr_data;
        4'h5: rpc <= ifc.wr_data;
        4'h8: ra <= ifc.wr_data[7:0];
        4'h9: rb <= ifc.wr_data[7:0];
        4'hA: rcc <= ifc.wr_data[7:0];
        4'hB: rdp <= ifc.wr_data[7:0];
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               nm, got, exp);
    end
  endtask

  // write monitor / scoreboard pop
  always @(negedge clk) begin
    if (ifc.done && !done_prev)
      done_cnt++;
    done_prev = ifc.done;
    if (rst_n && ifc.we) begin
      if (q.size() == 0) begin
        chk("unexpected_write",
            {12'h0, ifc.wr_id, ifc.wr_data},
            32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("write",
            {12'h0, ifc.wr_id, ifc.wr_data},
            {12'h0, e.id, e.d});
      end
    end
  end

  task automatic load(input int m);
    @(posedge clk); #1 ld = m;
    @(posedge clk); #1 ld = 0;
  endtask

  task automatic push(input logic [3:0] id,
                      input logic [15:0] d);
    wr_t w;
    w.id = id;
    w.d = d;
    q.push_back(w);
  endtask

  task automatic run(input logic [7:0] o,
                     input logic [7:0] p,
                     input bit tog,
                     input int lat,
                     input bit ill);
    int cyc;
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.op = o;
    ifc.postbyte = p;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    cen_tog = tog;
    cyc = 0;
    while (!ifc.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    cen_tog = 1'b0;
    chk("done_seen", {31'h0, ifc.done}, 1);
    if (!tog) chk("latency", cyc, lat);
    chk("illegal", {31'h0, ifc.illegal},
        {31'h0, ill & CHK});
    #3 cen = 1'b1;
    chk("pending", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int dc;
    ifc.start = 1'b0;
    ifc.op = 8'h00;
    ifc.postbyte = 8'h00;
    ld = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, ifc.busy}, 0);
    chk("rst_we", {31'h0, ifc.we}, 0);
    chk("rst_id", {28'h0, ifc.wr_id}, 0);
    chk("rst_data", {16'h0, ifc.wr_data}, 0);
    chk("rst_done", {31'h0, ifc.done}, 0);
    chk("rst_ill", {31'h0, ifc.illegal}, 0);
    ld = 0;
    rst_n = 1'b1;

    tv[0] = '{TFR_OP, 8'h12, 1, 4'h2, 16'h1234, 4'h0, 16'h0, 0};
    tv[1] = '{EXG_OP, 8'h89, 2, 4'h8, 16'hFFC3, 4'h9, 16'hFF5A, 0};
    tv[2] = '{TFR_OP, 8'h51, 1, 4'h1, 16'h8003, 4'h0, 16'h0, 0};
    tv[3] = '{TFR_OP, 8'h11, 1, 4'h1, 16'h1234, 4'h0, 16'h0, 0};
    tv[4] = '{EXG_OP, 8'h88, 2, 4'h8, 16'hFF5A, 4'h8, 16'hFF5A, 0};
    tv[5] = '{TFR_OP, 8'hA9, 1, 4'h9, 16'hFF22, 4'h0, 16'h0, 0};
    tv[6] = '{TFR_OP, 8'h18, 1, 4'h8, 16'h1234, 4'h0, 16'h0, 1};
    tv[7] = '{TFR_OP, 8'h6E, 0, 4'h0, 16'h0, 4'h0, 16'h0, 1};
    tv[8] = '{TFR_OP, 8'h61, 1, 4'h1, 16'h0000, 4'h0, 16'h0, 1};
    tv[9] = '{EXG_OP, 8'h23, 2, 4'h2, 16'h9ABC, 4'h3, 16'h5678, 0};

    for (int i = 0; i < 10; i++) begin
      load(1);
      if (tv[i].n > 0) push(tv[i].id0, tv[i].d0);
      if (tv[i].n > 1) push(tv[i].id1, tv[i].d1);
      run(tv[i].op, tv[i].pb, 1'b0,
          (tv[i].op == EXG_OP) ? 3 : 2,
          tv[i].ill);
    end

    // EXG D,X against a live bank
    load(1);
    load(2);
    push(4'h0, 16'h0042);
    push(4'h1, 16'hBEEF);
    run(EXG_OP, 8'h01, 1'b0, 3, 1'b0);
    chk("snap_d", {16'h0, ra, rb}, 32'h0042);
    chk("snap_x", {16'h0, rx}, 32'hBEEF);

    // cen toggling stretches the same EXG
    load(1);
    push(4'h8, 16'hFFC3);
    push(4'h9, 16'hFF5A);
    run(EXG_OP, 8'h89, 1'b1, 0, 1'b0);

    // second start while busy is dropped
    load(1);
    dc = done_cnt;
    push(4'h1, 16'h8003);
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.op = TFR_OP;
    ifc.postbyte = 8'h51;
    @(posedge clk); #1;
    ifc.op = EXG_OP;
    ifc.postbyte = 8'h89;
    chk("busy_hi", {31'h0, ifc.busy}, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_done", done_cnt, dc + 1);
    chk("busy_q", q.size(), 0);
    q.delete();

    // non-EXG/TFR opcode is ignored
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.op = 8'h12;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk("ign_busy", {31'h0, ifc.busy}, 0);
    chk("ign_done", {31'h0, ifc.done},
        {31'h0, CHK});
    chk("ign_ill", {31'h0, ifc.illegal},
        {31'h0, CHK});
    repeat (2) @(posedge clk);

    // reset in WR_LO keeps first write only
    load(1);
    dc = done_cnt;
    push(4'h8, 16'hFFC3);
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.op = EXG_OP;
    ifc.postbyte = 8'h89;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wrlo_id", {28'h0, ifc.wr_id}, 9);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'h0, ifc.busy}, 0);
    chk("rst_mid_we", {31'h0, ifc.we}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_done", done_cnt, dc);
    chk("rst_mid_q", q.size(), 0);
    chk("rst_mid_a", {24'h0, ra}, 32'hC3);
    chk("rst_mid_b", {24'h0, rb}, 32'hC3);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
